// File: rtl/store_align_unit.sv
// Store alignment unit: formats SB/SH/SW stores into word-aligned, lane-replicated memory
// writes through a 2-entry skid buffer. Optional trap on misaligned stores: STORE_MISALIGN_TRAP_EN.
module store_align_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_data,
  input  logic [1:0]        in_size,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              store_err,
  output logic [ADDR_W-1:0] err_addr
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        be;
  } entry_t;

  state_e state_q, state_d;
  entry_t out_q, skid_q, new_entry;
  logic   accept, drain, push, fmt_ok;
  logic [31:0] fmt_wdata;
  logic [3:0]  fmt_be;

  assign accept = in_valid && in_ready;
  assign drain  = mem_valid && mem_ready;

  always_comb begin
    fmt_wdata = '0;
    fmt_be    = '0;
    fmt_ok    = 1'b0;
    case (in_size)
      2'b00: begin
        fmt_wdata = {4{in_data[7:0]}};
        fmt_be    = 4'b0001 << in_addr[1:0];
        fmt_ok    = 1'b1;
      end
      2'b01: begin
        fmt_wdata = {2{in_data[15:0]}};
        fmt_be    = in_addr[1] ? 4'b1100 : 4'b0011;
        fmt_ok    = 1'b1;
      end
      2'b10: begin
        fmt_wdata = in_data;
        fmt_be    = 4'b1111;
        fmt_ok    = 1'b1;
      end
      default: ;
    endcase
  end

  assign new_entry = '{addr: {in_addr[ADDR_W-1:2], 2'b00}, wdata: fmt_wdata, be: fmt_be};

`ifdef STORE_MISALIGN_TRAP_EN
  logic              misaligned;
  logic              err_q;
  logic [ADDR_W-1:0] err_addr_q;

  assign misaligned = ((in_size == 2'b01) && in_addr[0]) ||
                      ((in_size == 2'b10) && (in_addr[1:0] != 2'b00));
  // Trapped stores are consumed here and never reach the buffer.
  assign push = accept && fmt_ok && !misaligned;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      err_q <= accept && misaligned;
      if (accept && misaligned) err_addr_q <= in_addr;
    end
  end

  assign store_err = err_q;
  assign err_addr  = err_addr_q;
`else
  assign push      = accept && fmt_ok;
  assign store_err = 1'b0;
  assign err_addr  = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StEmpty;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StEmpty: if (push) state_d = StOne;
      StOne: begin
        if (push && !drain)      state_d = StTwo;
        else if (drain && !push) state_d = StEmpty;
      end
      StTwo:   if (drain) state_d = StOne;
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    mem_valid = 1'b0;
    in_ready  = 1'b1;
    case (state_q)
      StOne:   mem_valid = 1'b1;
      StTwo: begin
        mem_valid = 1'b1;
        in_ready  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      case (state_q)
        StEmpty: if (push) out_q <= new_entry;
        StOne: begin
          if (push && drain) out_q  <= new_entry;
          else if (push)     skid_q <= new_entry;
        end
        StTwo:   if (drain) out_q <= skid_q;
        default: ;
      endcase
    end
  end

  assign mem_addr  = out_q.addr;
  assign mem_wdata = out_q.wdata;
  assign mem_be    = out_q.be;

endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit; inputs driven and outputs sampled on the falling edge.
module tb_store_align_unit;

  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [31:0]       in_data;
  logic [1:0]        in_size;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              store_err;
  logic [ADDR_W-1:0] err_addr;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_count = 0;

  store_align_unit #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .in_size  (in_size),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be   (mem_be),
    .store_err(store_err),
    .err_addr (err_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (reset_n && mem_valid && mem_ready) wr_count <= wr_count + 1;

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    in_size  = s;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (mem_valid !== 1'b0) begin n_bad++; $display("FAIL reset.mem_valid got %b want 0", mem_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset.in_ready got %b want 1", in_ready); end
    n_cmp++; if (store_err !== 1'b0) begin n_bad++; $display("FAIL reset.store_err got %b want 0", store_err); end
    n_cmp++; if ({mem_addr, mem_wdata, mem_be} !== '0) begin n_bad++; $display("FAIL reset.mem_out got %h/%h/%b want 0", mem_addr, mem_wdata, mem_be); end
    n_cmp++; if (err_addr !== '0) begin n_bad++; $display("FAIL reset.err_addr got %h want 0", err_addr); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_formats();
    logic [31:0] va [5] = '{32'h103, 32'h22, 32'h101, 32'h48, 32'h1E};
    logic [31:0] vd [5] = '{32'h0000_00A5, 32'h1234_BEEF, 32'h0000_005A, 32'hDEAD_BEEF, 32'h0000_CAFE};
    logic [1:0]  vs [5] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b01};
    logic [31:0] ea [5] = '{32'h100, 32'h20, 32'h100, 32'h48, 32'h1C};
    logic [31:0] ew [5] = '{32'hA5A5_A5A5, 32'hBEEF_BEEF, 32'h5A5A_5A5A, 32'hDEAD_BEEF, 32'hCAFE_CAFE};
    logic [3:0]  eb [5] = '{4'b1000, 4'b1100, 4'b0010, 4'b1111, 4'b1100};
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1'b1, va[i], vd[i], vs[i]);
      @(negedge clk);
      drive(1'b0, '0, '0, 2'b00);
      n_cmp++; if (mem_valid !== 1'b1) begin n_bad++; $display("FAIL fmt%0d.mem_valid got %b want 1", i, mem_valid); end
      n_cmp++; if (mem_addr !== ea[i]) begin n_bad++; $display("FAIL fmt%0d.mem_addr got %h want %h", i, mem_addr, ea[i]); end
      n_cmp++; if (mem_wdata !== ew[i]) begin n_bad++; $display("FAIL fmt%0d.mem_wdata got %h want %h", i, mem_wdata, ew[i]); end
      n_cmp++; if (mem_be !== eb[i]) begin n_bad++; $display("FAIL fmt%0d.mem_be got %b want %b", i, mem_be, eb[i]); end
      @(negedge clk);
      n_cmp++; if (mem_valid !== 1'b0) begin n_bad++; $display("FAIL fmt%0d.drained got %b want 0", i, mem_valid); end
    end
  endtask

  task automatic test_back_to_back();
    int w0;
    w0 = wr_count;
    mem_ready = 1'b0;
    @(negedge clk);
    drive(1'b1, 32'h100, 32'h1111_1111, 2'b10);
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b.ready_one got %b want 1", in_ready); end
    drive(1'b1, 32'h104, 32'h2222_2222, 2'b10);
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b.ready_two got %b want 0", in_ready); end
    n_cmp++; if (mem_addr !== 32'h100) begin n_bad++; $display("FAIL b2b.hold0 got %h want 100", mem_addr); end
    drive(1'b1, 32'h108, 32'h3333_3333, 2'b10);
    @(negedge clk);
    n_cmp++; if ({mem_addr, mem_wdata, mem_be} !== {32'h100, 32'h1111_1111, 4'b1111}) begin n_bad++; $display("FAIL b2b.hold1 got %h/%h/%b want 100/11111111/1111", mem_addr, mem_wdata, mem_be); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b.ready_stall got %b want 0", in_ready); end
    mem_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if ({mem_valid, mem_addr, mem_wdata} !== {1'b1, 32'h104, 32'h2222_2222}) begin n_bad++; $display("FAIL b2b.second got %b/%h/%h want 1/104/22222222", mem_valid, mem_addr, mem_wdata); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b.ready_after got %b want 1", in_ready); end
    @(negedge clk);
    drive(1'b0, '0, '0, 2'b00);
    n_cmp++; if ({mem_valid, mem_addr, mem_wdata} !== {1'b1, 32'h108, 32'h3333_3333}) begin n_bad++; $display("FAIL b2b.third got %b/%h/%h want 1/108/33333333", mem_valid, mem_addr, mem_wdata); end
    @(negedge clk);
    n_cmp++; if (mem_valid !== 1'b0) begin n_bad++; $display("FAIL b2b.empty got %b want 0", mem_valid); end
    n_cmp++; if (wr_count - w0 !== 3) begin n_bad++; $display("FAIL b2b.wr_count got %0d want 3", wr_count - w0); end
  endtask

  task automatic test_misalign();
    mem_ready = 1'b1;
    @(negedge clk);
    drive(1'b1, 32'h41, 32'h0BAD_F00D, 2'b10);
    @(negedge clk);
    drive(1'b0, '0, '0, 2'b00);
`ifdef STORE_MISALIGN_TRAP_EN
    n_cmp++; if (mem_valid !== 1'b0) begin n_bad++; $display("FAIL mis.mem_valid got %b want 0", mem_valid); end
    n_cmp++; if (store_err !== 1'b1) begin n_bad++; $display("FAIL mis.store_err got %b want 1", store_err); end
    n_cmp++; if (err_addr !== 32'h41) begin n_bad++; $display("FAIL mis.err_addr got %h want 41", err_addr); end
    @(negedge clk);
    n_cmp++; if (store_err !== 1'b0) begin n_bad++; $display("FAIL mis.pulse got %b want 0", store_err); end
    n_cmp++; if (err_addr !== 32'h41) begin n_bad++; $display("FAIL mis.err_hold got %h want 41", err_addr); end
`else
    n_cmp++; if ({mem_valid, mem_addr, mem_wdata, mem_be} !== {1'b1, 32'h40, 32'h0BAD_F00D, 4'b1111}) begin n_bad++; $display("FAIL mis.write got %b/%h/%h/%b want 1/40/0badf00d/1111", mem_valid, mem_addr, mem_wdata, mem_be); end
    n_cmp++; if ({store_err, err_addr} !== '0) begin n_bad++; $display("FAIL mis.err got %b/%h want 0/0", store_err, err_addr); end
    @(negedge clk);
    n_cmp++; if (mem_valid !== 1'b0) begin n_bad++; $display("FAIL mis.drained got %b want 0", mem_valid); end
`endif
  endtask

  task automatic test_reserved();
    int w0;
    w0 = wr_count;
    mem_ready = 1'b1;
    @(negedge clk);
    drive(1'b1, 32'h80, 32'hFFFF_FFFF, 2'b11);
    @(negedge clk);
    drive(1'b0, '0, '0, 2'b00);
    n_cmp++; if ({mem_valid, store_err, in_ready} !== 3'b001) begin n_bad++; $display("FAIL rsv.outputs got %b want 001", {mem_valid, store_err, in_ready}); end
    @(negedge clk);
    n_cmp++; if (wr_count - w0 !== 0) begin n_bad++; $display("FAIL rsv.wr_count got %0d want 0", wr_count - w0); end
  endtask

  task automatic test_reset_in_two();
    int w0;
    mem_ready = 1'b0;
    @(negedge clk);
    drive(1'b1, 32'h200, 32'h5555_5555, 2'b10);
    @(negedge clk);
    drive(1'b1, 32'h204, 32'h6666_6666, 2'b10);
    @(negedge clk);
    drive(1'b0, '0, '0, 2'b00);
    n_cmp++; if ({mem_valid, in_ready} !== 2'b10) begin n_bad++; $display("FAIL rst2.pre got %b want 10", {mem_valid, in_ready}); end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({mem_valid, in_ready} !== 2'b01) begin n_bad++; $display("FAIL rst2.async got %b want 01", {mem_valid, in_ready}); end
    n_cmp++; if ({mem_addr, mem_wdata, mem_be} !== '0) begin n_bad++; $display("FAIL rst2.mem_out got %h/%h/%b want 0", mem_addr, mem_wdata, mem_be); end
    @(negedge clk);
    reset_n   = 1'b1;
    mem_ready = 1'b1;
    w0 = wr_count;
    repeat (4) @(negedge clk);
    n_cmp++; if (wr_count - w0 !== 0) begin n_bad++; $display("FAIL rst2.wr_count got %0d want 0", wr_count - w0); end
    n_cmp++; if (mem_valid !== 1'b0) begin n_bad++; $display("FAIL rst2.idle got %b want 0", mem_valid); end
  endtask

  initial begin
    reset_n   = 1'b0;
    mem_ready = 1'b0;
    drive(1'b0, '0, '0, 2'b00);
    test_reset();
    test_formats();
    test_back_to_back();
    test_misalign();
    test_reserved();
    test_reset_in_two();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/store_align_unit.md
STORE_ALIGN_UNIT -- requirements
Module: store_align_unit

Interface
REQ-001 Parameter: ADDR_W, default 32, byte-address width; must be ≥ 3.
REQ-002 clk  input  1  rising-edge clock; sole clock domain.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  store request present.
REQ-005 in_ready  output  1  unit can accept a request this cycle.
REQ-006 in_addr  input  ADDR_W  byte address of store.
REQ-007 in_data  input  32  register value to store (low bits significant).
REQ-008 in_size  input  2  00 byte (SB), 01 halfword (SH), 10 word (SW), 11 reserved.
REQ-009 mem_valid  output  1  memory write request present.
REQ-010 mem_ready  input  1  memory accepts write this cycle.
REQ-011 mem_addr  output  ADDR_W  word-aligned address, {in_addr[ADDR_W-1:2], 2'b00}.
REQ-012 mem_wdata  output  32  lane-replicated write data.
REQ-013 mem_be  output  4  byte enables, bit n = byte lane n (little-endian).
REQ-014 store_err  output  1  one-cycle pulse on a misaligned store.
REQ-015 err_addr  output  ADDR_W  address of the most recent misaligned store.

Function
REQ-016 Request accepted on a rising edge when in_valid && in_ready; mem transfer completes when mem_valid && mem_ready.
REQ-017 Byte: mem_wdata = {4{in_data[7:0]}}; mem_be = 4'b0001 << in_addr[1:0].
REQ-018 Half: mem_wdata = {2{in_data[15:0]}}; mem_be = in_addr[1] ? 4'b1100 : 4'b0011; misaligned if in_addr[0] = 1.
REQ-019 Word: mem_wdata = in_data; mem_be = 4'b1111; misaligned if in_addr[1:0] != 0.
REQ-020 Byte stores are never misaligned.
REQ-021 Reserved size 11: accepted, silently dropped, no mem request and no store_err.
REQ-022 Latency: an accepted request appears on the mem_* outputs on the next rising edge (1 cycle).
REQ-023 Buffering: 2-entry skid (output register + skid register), states EMPTY, ONE, TWO.
REQ-024 EMPTY: accept → ONE.
REQ-025 ONE: accept && !drain → TWO; drain && !accept → EMPTY; accept && drain → ONE, new data loaded.
REQ-026 TWO: drain → ONE, skid entry moves to the output register; no accept is possible.
REQ-027 in_ready = 1 in EMPTY and ONE; in_ready = 0 in TWO; it is a registered function of state only, with no combinational path from mem_ready.
REQ-028 While mem_valid = 1 && mem_ready = 0, mem_addr, mem_wdata and mem_be are held stable.
REQ-029 Order is strictly preserved; no request is lost or duplicated.
REQ-030 mem_valid = 1 exactly in states ONE and TWO.

Reset
REQ-031 Asserting reset_n low immediately forces state EMPTY, mem_valid = 0, in_ready = 1, store_err = 0, mem_addr = 0, mem_wdata = 0, mem_be = 0, err_addr = 0.
REQ-032 Reset asserted mid-transfer discards all buffered entries; no write is issued after release.

Configuration
REQ-033 With STORE_MISALIGN_TRAP_EN defined, a misaligned store is accepted, produces no mem request, pulses store_err for the cycle after acceptance, and loads err_addr.
REQ-034 Without STORE_MISALIGN_TRAP_EN, misalignment is ignored: half uses in_addr[1] only, word uses be 4'b1111, the write proceeds normally, and store_err and err_addr stay 0.

Verification
REQ-035 SB addr 0x103, data 0x000000A5, mem_ready = 1 → next cycle mem_addr 0x100, mem_wdata 0xA5A5A5A5, mem_be 4'b1000.
REQ-036 SH addr 0x22, data 0x1234BEEF → mem_addr 0x20, mem_wdata 0xBEEFBEEF, mem_be 4'b1100.
REQ-037 Three back-to-back SW with mem_ready = 0 → in_ready drops after the 2nd; mem outputs stay stable; on mem_ready = 1, writes emerge in order 1, 2, 3.
REQ-038 SW addr 0x41 with the macro → no mem_valid, store_err = 1 for one cycle, err_addr 0x41; without the macro → write to 0x40 with be 4'b1111.
REQ-039 reset_n pulsed low in TWO → mem_valid = 0 immediately, in_ready = 1, no writes after release; in_size 11 → no output.
